// File: rtl/rgmii_rx_framer.sv
// rgmii_rx_framer: RGMII receive sequencer behind the DDR capture stage.
// Packs rise/fall nibbles into bytes, decodes RX_CTL into DV/ER, strips the
// preamble and SFD, and streams each frame out tagged with last and a bad flag.
// Output latency is three cycles: capture, hold, output register.
module rgmii_rx_framer #(
    parameter int PREAMBLE_MIN = 2,
    parameter int MIN_FRAME    = 64,
    parameter int MAX_FRAME    = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rxd_rise,
    input  logic [3:0] rxd_fall,
    input  logic       rx_ctl_rise,
    input  logic       rx_ctl_fall,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       m_user,
    output logic       stat_good,
    output logic       stat_bad,
    output logic       stat_drop
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  in_dat_q;
    logic        in_dv_q;
    logic        in_er_q;
    logic [3:0]  pcnt_q;
    logic [3:0]  pcnt_d;
    logic [15:0] len_q;
    logic [15:0] len_d;
    logic        err_q;
    logic        err_d;
    logic        frame_bad_d;
    logic [7:0]  hold_q;
    logic        hold_v_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q;
    logic        m_last_q;
    logic        m_user_q;
    logic        stat_good_q;
    logic        stat_bad_q;
    logic        stat_drop_q;

    // Stage 1: join the two nibbles into a byte and turn RX_CTL into DV/ER.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_dat_q <= 8'h00;
            in_dv_q  <= 1'b0;
            in_er_q  <= 1'b0;
        end else begin
            in_dat_q <= {rxd_fall, rxd_rise};
            in_dv_q  <= rx_ctl_rise;
            in_er_q  <= rx_ctl_rise ^ rx_ctl_fall;
        end
    end

    // Saturating preamble/length counters, sticky error and the end-of-frame verdict.
    always_comb begin
        pcnt_d      = (pcnt_q == 4'hF) ? pcnt_q : pcnt_q + 4'd1;
        len_d       = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
        err_d       = err_q | in_er_q;
        frame_bad_d = err_q | (len_q < 16'(MIN_FRAME)) | (len_q > 16'(MAX_FRAME));
    end

    // Framing FSM: one byte is kept in hold so the final byte can carry last/user.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pcnt_q      <= 4'd0;
            len_q       <= 16'd0;
            err_q       <= 1'b0;
            hold_q      <= 8'h00;
            hold_v_q    <= 1'b0;
            m_data_q    <= 8'h00;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_user_q    <= 1'b0;
            stat_good_q <= 1'b0;
            stat_bad_q  <= 1'b0;
            stat_drop_q <= 1'b0;
        end else begin
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_user_q    <= 1'b0;
            stat_good_q <= 1'b0;
            stat_bad_q  <= 1'b0;
            stat_drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_dv_q) begin
                        if (in_dat_q == 8'h55) begin
                            state_q <= PRE;
                            pcnt_q  <= 4'd1;
                        end else begin
                            state_q <= DROP;
                        end
                    end
                end
                PRE: begin
                    if (!in_dv_q) begin
                        state_q     <= IDLE;
                        stat_drop_q <= 1'b1;
                    end else if (in_dat_q == 8'h55) begin
                        pcnt_q <= pcnt_d;
                    end else if ((in_dat_q == 8'hD5) && (int'(pcnt_q) >= PREAMBLE_MIN)) begin
                        state_q  <= DATA;
                        len_q    <= 16'd0;
                        err_q    <= 1'b0;
                        hold_v_q <= 1'b0;
                    end else begin
                        state_q <= DROP;
                    end
                end
                DATA: begin
                    if (in_dv_q) begin
                        err_q <= err_d;
                        len_q <= len_d;
                        if (hold_v_q) begin
                            m_data_q  <= hold_q;
                            m_valid_q <= 1'b1;
                        end
                        hold_q   <= in_dat_q;
                        hold_v_q <= 1'b1;
                    end else begin
                        if (hold_v_q) begin
                            m_data_q    <= hold_q;
                            m_valid_q   <= 1'b1;
                            m_last_q    <= 1'b1;
                            m_user_q    <= frame_bad_d;
                            stat_good_q <= ~frame_bad_d;
                            stat_bad_q  <= frame_bad_d;
                        end else begin
                            stat_drop_q <= 1'b1;
                        end
                        hold_v_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                DROP: begin
                    if (!in_dv_q) begin
                        state_q     <= IDLE;
                        stat_drop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_user    = m_user_q;
    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;
    assign stat_drop = stat_drop_q;

endmodule
